csa_accumulate_resolve: RTL and testbench

Sink for carry-save pairs such as those produced by the 12:2 compressor tree. It accumulates a stream of (sum, carry) beats in redundant form without carry propagation. On the last beat of a group, it resolves the accumulator into a single two's-complement word using a chunked carry-propagate adder over several cycles, then presents the result on a valid/ready output. It sits between the compressor tree and any downstream consumer that needs binary results, for example activation or requantisation stages.

---
 rtl/csa_acc_pkg.sv | 25 ++
 rtl/compressor_4_2_n_bit.sv | 33 +++
 rtl/sign_extender.sv | 17 +
 rtl/csa_accumulate_resolve.sv | 125 ++++++++++++
 tb/tb_csa_accumulate_resolve.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/csa_acc_pkg.sv
// Shared types and helpers for the carry-save accumulate/resolve block.
package csa_acc_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  // Number of CHUNK-wide slices needed to cover an acc-wide word.
  function automatic int unsigned nchunk(input int unsigned acc, input int unsigned chunk);
    return (acc + chunk - 1) / chunk;
  endfunction

  // Replicate bit w-1 of v into every bit at or above w.
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic [63:0] r;
    r = v;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i >= w) r[i] = v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/compressor_4_2_n_bit.sv
// N-bit 4:2 compressor built from two carry-save layers.
// Outputs wrap at IN_SIZE bits: o_sum + o_carry == a+b+c+d mod 2^IN_SIZE.
module compressor_4_2_n_bit #(
  parameter int unsigned IN_SIZE = 32
) (
  input  logic [IN_SIZE-1:0] i_a,
  input  logic [IN_SIZE-1:0] i_b,
  input  logic [IN_SIZE-1:0] i_c,
  input  logic [IN_SIZE-1:0] i_d,
  output logic [IN_SIZE-1:0] o_sum,
  output logic [IN_SIZE-1:0] o_carry
);

  logic [IN_SIZE-1:0] w_s1;
  logic [IN_SIZE-1:0] w_c1;
  logic [IN_SIZE-2:0] w_m1;
  logic [IN_SIZE-2:0] w_m2;

  // Two stacked 3:2 layers; the majority of the top bit is shifted out, so it is never formed.
  always_comb begin
    w_s1    = i_a ^ i_b ^ i_c;
    w_m1    = (i_a[IN_SIZE-2:0] & i_b[IN_SIZE-2:0]) |
              (i_a[IN_SIZE-2:0] & i_c[IN_SIZE-2:0]) |
              (i_b[IN_SIZE-2:0] & i_c[IN_SIZE-2:0]);
    w_c1    = {w_m1, 1'b0};
    o_sum   = w_s1 ^ w_c1 ^ i_d;
    w_m2    = (w_s1[IN_SIZE-2:0] & w_c1[IN_SIZE-2:0]) |
              (w_s1[IN_SIZE-2:0] & i_d[IN_SIZE-2:0])  |
              (w_c1[IN_SIZE-2:0] & i_d[IN_SIZE-2:0]);
    o_carry = {w_m2, 1'b0};
  end

endmodule

// File: rtl/sign_extender.sv
// Widens a two's-complement vector from IN_SIZE to OUT_SIZE bits.
module sign_extender
  import csa_acc_pkg::*;
#(
  parameter int unsigned IN_SIZE  = 21,
  parameter int unsigned OUT_SIZE = 32
) (
  input  logic [IN_SIZE-1:0]  i_in,
  output logic [OUT_SIZE-1:0] o_out
);

  // Pure combinational widening through the package helper.
  always_comb begin
    o_out = OUT_SIZE'(sext(64'(i_in), IN_SIZE));
  end

endmodule

// File: rtl/csa_accumulate_resolve.sv
// Accumulates (sum, carry) beats in redundant form and resolves each group
// to a binary word with a CHUNK-bit-per-cycle carry-propagate adder.
module csa_accumulate_resolve
  import csa_acc_pkg::*;
#(
  parameter int unsigned IN_SIZE  = 21,
  parameter int unsigned ACC_SIZE = 32,
  parameter int unsigned CHUNK    = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [IN_SIZE-1:0]  sum_i,
  input  logic [IN_SIZE-1:0]  carry_i,
  input  logic                last_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [ACC_SIZE-1:0] result_o
);

  localparam int unsigned NCHUNK = nchunk(ACC_SIZE, CHUNK);
  localparam int unsigned PW     = NCHUNK * CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t              r_state;
  logic [ACC_SIZE-1:0] r_acc_s;
  logic [ACC_SIZE-1:0] r_acc_c;
  logic [ACC_SIZE-1:0] r_result;
  logic [KW-1:0]       r_k;
  logic                r_cy;

  logic [ACC_SIZE-1:0] w_ext_s;
  logic [ACC_SIZE-1:0] w_ext_c;
  logic [ACC_SIZE-1:0] w_cmp_s;
  logic [ACC_SIZE-1:0] w_cmp_c;
  logic [31:0]         w_sh;
  logic [CHUNK-1:0]    w_chunk_s;
  logic [CHUNK-1:0]    w_chunk_c;
  logic [CHUNK:0]      w_add;
  logic [PW-1:0]       w_mask;
  logic [PW-1:0]       w_ins;
  logic [ACC_SIZE-1:0] w_result_nxt;
  logic                w_accept;

  sign_extender #(.IN_SIZE(IN_SIZE), .OUT_SIZE(ACC_SIZE)) u_sext_s (
    .i_in  (sum_i),
    .o_out (w_ext_s)
  );

  sign_extender #(.IN_SIZE(IN_SIZE), .OUT_SIZE(ACC_SIZE)) u_sext_c (
    .i_in  (carry_i),
    .o_out (w_ext_c)
  );

  compressor_4_2_n_bit #(.IN_SIZE(ACC_SIZE)) u_cmp (
    .i_a     (r_acc_s),
    .i_b     (r_acc_c),
    .i_c     (w_ext_s),
    .i_d     (w_ext_c),
    .o_sum   (w_cmp_s),
    .o_carry (w_cmp_c)
  );

  // Handshake decode; both flags come from the state register only.
  always_comb begin
    ready_o  = (r_state == ACCUM);
    valid_o  = (r_state == OUTPUT);
    result_o = r_result;
    w_accept = valid_i && ready_o;
  end

  // Slice chunk k out of both accumulator halves, add with the running carry,
  // and splice the CHUNK result bits into the result word.
  always_comb begin
    w_sh         = 32'(r_k) * CHUNK;
    w_chunk_s    = CHUNK'(PW'(r_acc_s) >> w_sh);
    w_chunk_c    = CHUNK'(PW'(r_acc_c) >> w_sh);
    w_add        = {1'b0, w_chunk_s} + {1'b0, w_chunk_c} + (CHUNK+1)'(r_cy);
    w_mask       = PW'({CHUNK{1'b1}}) << w_sh;
    w_ins        = PW'(w_add[CHUNK-1:0]) << w_sh;
    w_result_nxt = ACC_SIZE'((PW'(r_result) & ~w_mask) | w_ins);
  end

  // Control FSM plus accumulator, chunk adder state and result register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ACCUM;
      r_acc_s  <= '0;
      r_acc_c  <= '0;
      r_result <= '0;
      r_k      <= '0;
      r_cy     <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_acc_s <= w_cmp_s;
            r_acc_c <= w_cmp_c;
            if (last_i) begin
              r_state <= RESOLVE;
              r_k     <= '0;
              r_cy    <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          r_result <= w_result_nxt;
          r_cy     <= w_add[CHUNK];
          r_k      <= r_k + 1'b1;
          if (r_k == KW'(NCHUNK - 1)) r_state <= OUTPUT;
        end
        OUTPUT: begin
          if (ready_i) begin
            r_acc_s <= '0;
            r_acc_c <= '0;
            r_state <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulate_resolve.sv
// Directed self-checking bench for csa_accumulate_resolve.
module tb_csa_accumulate_resolve;

  logic        clk_i;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [20:0] sum_i;
  logic [20:0] carry_i;
  logic        last_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;

  int n_vec;
  int n_err;

  csa_accumulate_resolve #(.IN_SIZE(21), .ACC_SIZE(32), .CHUNK(8)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .sum_i    (sum_i),
    .carry_i  (carry_i),
    .last_i   (last_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Present one beat and let it be taken at the next edge; valid_i stays high.
  task automatic drive_beat(input logic [20:0] s, input logic [20:0] c, input logic l);
    valid_i = 1'b1;
    sum_i   = s;
    carry_i = c;
    last_i  = l;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0;
    sum_i   = '0;
    carry_i = '0;
    last_i  = 1'b0;
  endtask

  // Called right after the last beat's edge: walk the 4 resolve cycles and check the result.
  task automatic resolve_and_check(input string name, input logic [31:0] exp);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk_i);
      #1;
      n_vec++;
      if (valid_o !== (i == 4)) begin
        $display("FAIL %s valid_o cycle %0d: got %b want %b", name, i, valid_o, (i == 4));
        n_err++;
      end
      n_vec++;
      if (ready_o !== 1'b0) begin
        $display("FAIL %s ready_o cycle %0d: got %b want 0", name, i, ready_o);
        n_err++;
      end
    end
    n_vec++;
    if (result_o !== exp) begin
      $display("FAIL %s result_o: got %h want %h", name, result_o, exp);
      n_err++;
    end
  endtask

  task automatic handshake(input string name);
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    n_vec++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      $display("FAIL %s post-handshake: got ready=%b valid=%b want ready=1 valid=0", name, ready_o, valid_o);
      n_err++;
    end
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    ready_i = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    n_vec++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0) begin
      $display("FAIL reset: got ready=%b valid=%b result=%h want 1 0 00000000", ready_o, valid_o, result_o);
      n_err++;
    end
  endtask

  task automatic test_single_beat();
    drive_beat(21'd5, 21'd3, 1'b1);
    idle_inputs();
    resolve_and_check("single", 32'h0000_0008);
    handshake("single");
  endtask

  task automatic test_three_beat();
    drive_beat(21'd100, 21'h1FFFFF, 1'b0);
    n_vec++;
    if (ready_o !== 1'b1) begin
      $display("FAIL three_beat ready_o mid-group: got %b want 1", ready_o);
      n_err++;
    end
    drive_beat(21'h1FFFCE, 21'd0, 1'b0);
    drive_beat(21'd7, 21'd8, 1'b1);
    idle_inputs();
    resolve_and_check("three_beat", 32'd64);
    @(posedge clk_i);
    #1;
    n_vec++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
      $display("FAIL three_beat hold: got ready=%b valid=%b want 0 1", ready_o, valid_o);
      n_err++;
    end
    handshake("three_beat");
  endtask

  task automatic test_chunk_carry();
    drive_beat(21'h0000FF, 21'h000001, 1'b1);
    idle_inputs();
    resolve_and_check("carry_ff", 32'h0000_0100);
    handshake("carry_ff");
    drive_beat(21'h1FFFFF, 21'h000001, 1'b1);
    idle_inputs();
    resolve_and_check("carry_ripple", 32'h0000_0000);
    handshake("carry_ripple");
  endtask

  task automatic test_negative_extreme();
    drive_beat(21'h100000, 21'h100000, 1'b1);
    idle_inputs();
    resolve_and_check("neg_extreme", 32'hFFE0_0000);
    handshake("neg_extreme");
  endtask

  task automatic test_backpressure();
    drive_beat(21'd10, 21'd20, 1'b1);
    idle_inputs();
    resolve_and_check("bp", 32'd30);
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'b1;
      sum_i   = 21'd1000;
      carry_i = 21'd1000;
      last_i  = 1'b1;
      @(posedge clk_i);
      #1;
      n_vec++;
      if (valid_o !== 1'b1 || result_o !== 32'd30 || ready_o !== 1'b0) begin
        $display("FAIL bp hold cycle %0d: got valid=%b ready=%b result=%h want 1 0 0000001e", i, valid_o, ready_o, result_o);
        n_err++;
      end
    end
    idle_inputs();
    handshake("bp");
    drive_beat(21'd1, 21'd1, 1'b1);
    idle_inputs();
    resolve_and_check("bp_next", 32'd2);
    handshake("bp_next");
  endtask

  task automatic test_reset_mid_resolve();
    drive_beat(21'd9, 21'd9, 1'b1);
    idle_inputs();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    n_vec++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'h0) begin
      $display("FAIL rst_mid: got valid=%b ready=%b result=%h want 0 1 00000000", valid_o, ready_o, result_o);
      n_err++;
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    drive_beat(21'd2, 21'd3, 1'b1);
    idle_inputs();
    resolve_and_check("rst_next", 32'd5);
    handshake("rst_next");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_beat();
    test_three_beat();
    test_chunk_carry();
    test_negative_extreme();
    test_backpressure();
    test_reset_mid_resolve();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
